// File: rtl/int_nest_ctrl.sv
// Nested, prioritised interrupt controller: synchronised edge-detected sources, mask,
// vectored Int/int_ack redirect and a resume-PC stack. Define INT_PREEMPT_EN to enable preemption.
module int_nest_ctrl #(
    parameter int          DEPTH    = 3,
    parameter logic [31:0] IR1_ADDR = 32'h0000_0009,
    parameter logic [31:0] IR2_ADDR = 32'h0000_00c8,
    parameter logic [31:0] IR3_ADDR = 32'h0000_016c
) (
    input  logic        clk,
    input  logic        CLR_n,
    input  logic [2:0]  ir,
    input  logic        mask_we,
    input  logic [2:0]  mask_wdata,
    input  logic        eret,
    input  logic        int_ack,
    input  logic [31:0] pc_resume,
    output logic        Int,
    output logic [31:0] Iaddr,
    output logic [31:0] EPC,
    output logic [1:0]  cur_ir,
    output logic [2:0]  pending,
    output logic [1:0]  nest_level
);

`ifdef INT_PREEMPT_EN
    localparam int EFF_DEPTH = DEPTH;
    localparam bit PREEMPT   = 1'b1;
`else
    localparam int EFF_DEPTH = 1;
    localparam bit PREEMPT   = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_REQ} state_e;

    state_e      state_q, state_d;
    logic [2:0]  sync1_q, sync2_q, dly_q;
    logic [2:0]  pend_q, pend_d, mask_q, rise, clr, eligible;
    logic [1:0]  sel_q, sel_d, cur_q, cur_d, nest_q, nest_d;
    logic [1:0]  winner, run_lvl, top_idx, cur_after_pop, nest_after_pop, top_id;
    logic [31:0] top_pc;
    logic        pop, ack, push, can_dispatch;
    logic [31:0] pc_stk_q [DEPTH];
    logic [1:0]  id_stk_q [DEPTH];

    // ID 1 (ir1) is the most urgent source, so it carries the highest level.
    function automatic logic [1:0] level_of(input logic [1:0] id);
        case (id)
            2'd1:    return 2'd3;
            2'd2:    return 2'd2;
            2'd3:    return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] vector_of(input logic [1:0] id);
        case (id)
            2'd1:    return IR1_ADDR;
            2'd2:    return IR2_ADDR;
            2'd3:    return IR3_ADDR;
            default: return 32'h0;
        endcase
    endfunction

    assign rise    = sync2_q & ~dly_q;
    assign pop     = eret && (nest_q != 2'd0);
    assign ack     = int_ack && (state_q == S_REQ);
    assign top_idx = nest_q - 2'd1;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        top_pc = 32'h0;
        top_id = 2'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (top_idx == 2'(i)) begin
                top_pc = pc_stk_q[i];
                top_id = id_stk_q[i];
            end
        end

        run_lvl = level_of(cur_q);
        for (int i = 0; i < 3; i++) begin
            eligible[i] = pend_q[i] & ~mask_q[i] & (level_of(2'(i + 1)) > run_lvl);
        end
        if (!PREEMPT && cur_q != 2'd0) eligible = 3'b000;

        winner = eligible[0] ? 2'd1 : eligible[1] ? 2'd2 : eligible[2] ? 2'd3 : 2'd0;
        can_dispatch = (winner != 2'd0) && (int'(nest_q) < EFF_DEPTH);

        // A same-cycle eret pops before the acknowledged handler is pushed.
        cur_after_pop  = pop ? top_id : cur_q;
        nest_after_pop = nest_q - {1'b0, pop};

        state_d = state_q;
        sel_d   = sel_q;
        cur_d   = cur_after_pop;
        nest_d  = nest_after_pop;
        clr     = 3'b000;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (can_dispatch) begin
                    state_d = S_REQ;
                    sel_d   = winner;
                end
            end
            S_REQ: begin
                if (ack) begin
                    push    = 1'b1;
                    cur_d   = sel_q;
                    nest_d  = nest_after_pop + 2'd1;
                    clr     = 3'b001 << (sel_q - 2'd1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pend_d = (pend_q & ~clr) | rise;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            dly_q   <= 3'b000;
            pend_q  <= 3'b000;
            mask_q  <= 3'b000;
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            cur_q   <= 2'd0;
            nest_q  <= 2'd0;
        end else begin
            sync1_q <= ir;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            pend_q  <= pend_d;
            if (mask_we) mask_q <= mask_wdata;
            state_q <= state_d;
            sel_q   <= sel_d;
            cur_q   <= cur_d;
            nest_q  <= nest_d;
        end
    end

    // NOTE: stack entries are only read below nest_level, so they need no reset.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stk
        always_ff @(posedge clk) begin
            if (push && nest_after_pop == 2'(g)) begin
                pc_stk_q[g] <= pc_resume;
                id_stk_q[g] <= cur_after_pop;
            end
        end
    end

    assign Int        = (state_q == S_REQ);
    assign Iaddr      = Int ? vector_of(sel_q) : 32'h0;
    assign EPC        = (nest_q == 2'd0) ? 32'h0 : top_pc;
    assign cur_ir     = cur_q;
    assign pending    = pend_q;
    assign nest_level = nest_q;

endmodule

// File: doc/int_nest_ctrl.md
Name: int_nest_ctrl

Overview:
- Nested, prioritised interrupt controller for the pipelined CPU.
- Accepts three raw asynchronous interrupt lines, synchronises and latches them as pending, applies a mask, and issues a vectored redirect (Int, Iaddr) to the fetch stage.
- Uses an Int/int_ack handshake with the pipeline.
- Keeps a nesting stack of resume PCs and preempted IDs, so a higher-priority source can preempt a running handler; eret unwinds the stack.

Parameters:
- DEPTH, 3: nesting stack depth (1..3 max handlers active).
- IR1_ADDR, 32'h00000009: vector for ir1 (highest priority, level 3).
- IR2_ADDR, 32'h000000c8: vector for ir2 (level 2).
- IR3_ADDR, 32'h0000016c: vector for ir3 (lowest, level 1).

Ports:
- clk  in  1  system clock, rising edge.
- CLR_n  in  1  asynchronous active-low reset.
- ir  in  3  raw async interrupt lines; bit0=ir1, bit1=ir2, bit2=ir3.
- mask_we  in  1  write enable for mask register.
- mask_wdata  in  3  new mask; 1 = source masked.
- eret  in  1  one-cycle pulse, handler return retired.
- int_ack  in  1  pipeline has taken the redirect; pc_resume valid.
- pc_resume  in  32  PC to resume at after the handler (from EPC logic).
- Int  out  1  redirect request, held until int_ack.
- Iaddr  out  32  handler vector, valid while Int=1.
- EPC  out  32  top-of-stack resume PC; 0 when stack empty.
- cur_ir  out  2  ID of running handler; 0 = none.
- pending  out  3  latched pending bits.
- nest_level  out  2  number of stacked handlers.

Behaviour:
- Reset (CLR_n=0, async):
  - Int=0, Iaddr=0, EPC=0, cur_ir=0, pending=0, nest_level=0.
  - mask=0, sync flops=0, FSM=IDLE.
- Input path, per line:
  - 2-flop synchroniser plus one delay flop; rising-edge detect sets pending.
  - ir rising before edge E1 → pending=1 after E3.
  - Level-held ir sets pending once only; a re-set requires a low period of ≥2 cycles.
  - An edge arriving while already pending is coalesced.
  - Set and clear in the same cycle: set wins.
- Priority:
  - Running level = level of cur_ir (0 if none).
  - eligible = pending & ~mask & level(src) > running level.
  - Highest eligible source wins; fixed order ir1>ir2>ir3.
- FSM IDLE:
  - If eligible≠0 and nest_level<DEPTH: go to REQ next edge, register sel=winner, Int=1, Iaddr=vector(sel).
  - Pending a dispatch after E3 → Int=1 after E4.
- FSM REQ:
  - Int and Iaddr held stable; sel frozen even if a higher source arrives or mask changes.
  - On int_ack:
    - push {pc_resume, cur_ir}; cur_ir=sel; clear pending[sel]; nest_level+1.
    - Int=0, go to IDLE.
    - IDLE re-evaluates one cycle later, so minimum spacing between Int pulses is 2 cycles.
- eret:
  - EPC is combinational from the stack top, so the pipeline reads it in the eret cycle.
  - Next edge: pop, restoring cur_ir; nest_level-1.
  - eret with nest_level=0: ignored, no state change.
  - eret concurrent with int_ack: pop first, then push. Net nest_level is unchanged; the new handler's stacked cur_ir is the popped one.
  - eret while in REQ: pop applied, Int stays asserted.
- Stack full (nest_level=DEPTH): no new Int; pending bits retained.
- mask:
  - Written at the edge after mask_we=1; affects eligibility only, never clears pending.
  - Unmasking a pending source dispatches normally.
- int_ack while Int=0: ignored.

Optional Feature:
- Macro INT_PREEMPT_EN.
- Defined: nesting/preemption as above.
- Undefined:
  - No preemption: dispatch only when cur_ir=0.
  - Stack is effectively depth 1 regardless of DEPTH; nest_level ∈ {0,1}.
  - Higher-priority sources stay pending until eret.

Test Plan:
- Reset mid-REQ:
  - Stimulus: ir2 pulse, Int=1; assert CLR_n=0 mid-cycle.
  - Required: all outputs 0 immediately; no Int after release until a new edge.
- Single dispatch:
  - Stimulus: ir3 rise; int_ack with pc_resume=32'h40.
  - Required: Int=1 after 4th edge with Iaddr=32'h16c; after ack cur_ir=3, EPC=32'h40, pending=0.
  - Then eret → nest_level=0, EPC=0.
- Simultaneous sources:
  - Stimulus: ir1, ir2, ir3 rise on the same cycle.
  - Required: dispatch order ir1 (32'h9), then ir2 (32'hc8) after ir1 eret, then ir3.
- Preemption (INT_PREEMPT_EN):
  - Stimulus: ir3 running (EPC=32'h40); ir1 rises; ack with pc_resume=32'h123.
  - Required: Int with 32'h9; EPC=32'h123, nest_level=2.
  - eret → EPC=32'h40, cur_ir=3.
  - Without the macro: ir1 stays pending until ir3's eret.
- Mask, coalescing and spurious eret:
  - Stimulus: mask=3'b010, ir2 pulsed twice.
  - Required: pending[1]=1, no Int; unmask → exactly one dispatch at 32'hc8.
  - Stimulus: eret with empty stack.
  - Required: no change.
- Stack full:
  - Stimulus: DEPTH=1, ir3 running, ir1 rises.
  - Required: no Int; pending[0]=1; after eret, ir1 dispatched.
